ysyx_23060171_mcore: RTL and testbench
======================================

YSYX_23060171_MCORE -- requirements
Module: ysyx_23060171_mcore

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, pc value loaded at reset.
REQ-002 SHALL have parameter NR_GPR, default 32, number of GPRs; legal values 16 (RV32E) or 32.
REQ-003 SHALL have parameter IFU_TIMEOUT, default 255, max cycles in FETCH_WAIT before fault; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ifu_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port ifu_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port ifu_addr  output  32  fetch address, equal to pc.
REQ-009 SHALL have port ifu_rsp_valid  input  1  instruction word valid.
REQ-010 SHALL have port ifu_rsp_inst  input  32  fetched instruction.
REQ-011 SHALL have port pc  output  32  address of the instruction in flight.
REQ-012 SHALL have port commit  output  1  one-cycle pulse per retired instruction.
REQ-013 SHALL have port halt  output  1  core stopped (ebreak or fault), sticky.
REQ-014 SHALL have port fault  output  2  0 none, 1 ebreak, 2 illegal instruction, 3 fetch timeout.

Function
REQ-015 SHALL implement FSM states FETCH_REQ, FETCH_WAIT, EXEC, HALT.
REQ-016 FETCH_REQ SHALL drive ifu_req_valid=1, ifu_addr=pc held stable until ifu_req_ready=1; on handshake go to FETCH_WAIT.
REQ-017 FETCH_WAIT SHALL hold ifu_req_valid=0, latch ifu_rsp_inst on ifu_rsp_valid=1 and go to EXEC; ifu_rsp_valid in any other state SHALL be ignored.
REQ-018 FETCH_WAIT SHALL count cycles; when count reaches IFU_TIMEOUT (nonzero) go to HALT with fault=3.
REQ-019 EXEC SHALL take exactly one cycle: decode, execute, write rd, update pc, pulse commit, return to FETCH_REQ.
REQ-020 Minimum instruction latency SHALL be 3 cycles (req accepted, rsp in next cycle, EXEC).
REQ-021 Supported: addi, add, lui, auipc, jal, jalr, ebreak; any other encoding SHALL be illegal.
REQ-022 With NR_GPR=16, any used rs1/rs2/rd index >=16 SHALL be illegal.
REQ-023 Illegal in EXEC SHALL: no GPR write, pc unchanged, no commit, go HALT, fault=2.
REQ-024 ebreak in EXEC SHALL: pulse commit, pc unchanged, go HALT, fault=1.
REQ-025 Writes to x0 SHALL be discarded; x0 SHALL read 0.
REQ-026 All arithmetic SHALL be 32-bit modulo 2^32; pc+4 and branch targets wrap silently.
REQ-027 jal/jalr SHALL write old pc+4 to rd; jalr target=(rs1+imm) with bit 0 cleared; rd==rs1 SHALL use pre-write rs1.
REQ-028 Immediates SHALL be sign-extended per I/U/J formats; lui writes imm[31:12]<<12; auipc writes pc+that.
REQ-029 HALT SHALL be terminal until rst: ifu_req_valid=0, commit=0, pc and fault frozen.
REQ-030 Misaligned jump targets (bit 1 set) SHALL be fetched as-is; alignment checking is out of scope.

Reset
REQ-031 rst=1 SHALL, at the next edge, set pc=RESET_PC, state=FETCH_REQ, all GPRs=0, commit=0, halt=0, fault=0, timeout count=0.
REQ-032 rst SHALL override any state including mid-handshake; a response arriving after reset with no new request SHALL be ignored.
REQ-033 While rst=1 outputs SHALL show reset values; ifu_req_valid SHALL be 0.

Verification
REQ-034 Reset, ready=1, rsp next cycle with addi x1,x0,5 (32'h00500093) -> x1=5, commit pulse on cycle 3, pc=32'h8000_0004.
REQ-035 ifu_req_ready low 4 cycles -> ifu_req_valid and ifu_addr=32'h8000_0000 stable all 4 cycles, single handshake.
REQ-036 jalr x1,0(x1) with x1=32'h8000_0011 -> pc=32'h8000_0010, x1=old pc+4.
REQ-037 NR_GPR=16, add x17,x1,x2 -> halt=1, fault=2, commit never pulses, pc unchanged.
REQ-038 IFU_TIMEOUT=3, no ifu_rsp_valid -> halt with fault=3 after 3 FETCH_WAIT cycles; rst then restarts fetch at RESET_PC.
REQ-039 ebreak (32'h00100073) -> one commit pulse, halt=1, fault=1; later ifu_rsp_valid ignored.

Source files
------------

// File: rtl/ysyx_23060171_mcore.sv
// ysyx_23060171_mcore: multi-cycle RV32I/E subset core (addi, add, lui, auipc, jal, jalr, ebreak)
module ysyx_23060171_mcore #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          NR_GPR      = 32,
  parameter int unsigned IFU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] pc,
  output logic        commit,
  output logic        halt,
  output logic [1:0]  fault
);
  localparam int AW = $clog2(NR_GPR);
  typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, EXEC, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, cnt_q, cnt_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] rf [NR_GPR];
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_addi, is_add, is_lui, is_auipc, is_jal, is_jalr, is_ebreak;
  logic        uses_rd, uses_rs1, bad_idx, legal, wen;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_u, imm_j, pc4, wdata, npc;
  assign op        = inst_q[6:0];
  assign f3        = inst_q[14:12];
  assign f7        = inst_q[31:25];
  assign rd        = inst_q[11:7];
  assign rs1       = inst_q[19:15];
  assign rs2       = inst_q[24:20];
  assign is_addi   = op == 7'h13 && f3 == 3'd0;
  assign is_add    = op == 7'h33 && f3 == 3'd0 && f7 == 7'd0;
  assign is_lui    = op == 7'h37;
  assign is_auipc  = op == 7'h17;
  assign is_jal    = op == 7'h6f;
  assign is_jalr   = op == 7'h67 && f3 == 3'd0;
  assign is_ebreak = inst_q == 32'h0010_0073;
  assign uses_rd   = is_addi | is_add | is_lui | is_auipc | is_jal | is_jalr;
  assign uses_rs1  = is_addi | is_add | is_jalr;
  // RV32E: only register fields the instruction actually uses are range-checked
  assign bad_idx   = NR_GPR == 16 && ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (is_add && rs2[4]));
  assign legal     = (uses_rd | is_ebreak) & ~bad_idx;
  assign rs1_v     = rf[rs1[AW-1:0]];
  assign rs2_v     = rf[rs2[AW-1:0]];
  assign imm_i     = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_u     = {inst_q[31:12], 12'd0};
  assign imm_j     = {{12{inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
  assign pc4       = pc_q + 32'd4;
  assign wdata     = is_addi ? rs1_v + imm_i : is_add ? rs1_v + rs2_v : is_lui ? imm_u :
                     is_auipc ? pc_q + imm_u : pc4;
  assign npc       = is_jal ? pc_q + imm_j : is_jalr ? (rs1_v + imm_i) & ~32'd1 : pc4;
  assign wen       = state_q == EXEC && legal && uses_rd && rd != 5'd0;
  assign rf[0]     = '0;
  for (genvar r = 1; r < NR_GPR; r++) begin : g_gpr
    logic [31:0] x_q;
    always_ff @(posedge clk) begin
      if (rst) x_q <= '0;
      else if (wen && rd[AW-1:0] == AW'(r)) x_q <= wdata;
    end
    assign rf[r] = x_q;
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      FETCH_REQ: begin
        state_d = ifu_req_ready ? FETCH_WAIT : FETCH_REQ;
        cnt_d   = '0;
      end
      FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_inst;
          state_d = EXEC;
        end else if (IFU_TIMEOUT != 0 && cnt_q + 32'd1 == IFU_TIMEOUT) begin
          state_d = HALT;
          fault_d = 2'd3;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      EXEC: begin
        state_d = (legal && !is_ebreak) ? FETCH_REQ : HALT;
        fault_d = !legal ? 2'd2 : is_ebreak ? 2'd1 : 2'd0;
        pc_d    = (legal && !is_ebreak) ? npc : pc_q;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  // outputs are forced to reset values combinationally while rst is held
  assign ifu_req_valid = !rst && state_q == FETCH_REQ;
  assign pc            = rst ? RESET_PC : pc_q;
  assign ifu_addr      = pc;
  assign commit        = !rst && state_q == EXEC && legal;
  assign halt          = !rst && state_q == HALT;
  assign fault         = rst ? 2'd0 : fault_q;
endmodule

// File: tb/tb_ysyx_23060171_mcore.sv
// tb_ysyx_23060171_mcore: random + directed check of both core configs against an ISA-level model
module tb_ysyx_23060171_mcore;
  typedef enum {K_ADDI, K_ADD, K_LUI, K_AUIPC, K_JAL, K_JALR, K_EBREAK, K_ILL} kind_t;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 0, rst = 1, ready = 0, rsp_valid = 0;
  logic [31:0] rsp_inst = 0;
  logic a_valid, a_commit, a_halt, b_valid, b_commit, b_halt;
  logic [31:0] a_addr, a_pc, b_addr, b_pc;
  logic [1:0] a_fault, b_fault;
  logic sel = 0;
  logic o_valid, o_commit, o_halt;
  logic [31:0] o_addr, o_pc;
  logic [1:0] o_fault;
  int n_vec = 0, n_err = 0;
  logic [31:0] m_x [32];
  logic [31:0] m_pc;
  logic m_halt;
  logic [1:0] m_fault;
  always #5 clk = ~clk;
  ysyx_23060171_mcore dut (.clk(clk), .rst(rst), .ifu_req_valid(a_valid), .ifu_req_ready(ready),
    .ifu_addr(a_addr), .ifu_rsp_valid(rsp_valid), .ifu_rsp_inst(rsp_inst), .pc(a_pc),
    .commit(a_commit), .halt(a_halt), .fault(a_fault));
  ysyx_23060171_mcore #(.NR_GPR(16), .IFU_TIMEOUT(3)) dut_e (.clk(clk), .rst(rst),
    .ifu_req_valid(b_valid), .ifu_req_ready(ready), .ifu_addr(b_addr), .ifu_rsp_valid(rsp_valid),
    .ifu_rsp_inst(rsp_inst), .pc(b_pc), .commit(b_commit), .halt(b_halt), .fault(b_fault));
  assign o_valid  = sel ? b_valid : a_valid;
  assign o_addr   = sel ? b_addr : a_addr;
  assign o_pc     = sel ? b_pc : a_pc;
  assign o_commit = sel ? b_commit : a_commit;
  assign o_halt   = sel ? b_halt : a_halt;
  assign o_fault  = sel ? b_fault : a_fault;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cfg %0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask
  function automatic logic [31:0] enc(input kind_t k, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
    logic [31:0] ill [6] = '{32'h0000_0000, 32'h0000_0073, 32'h4010_80b3, 32'h0010_9093,
                             32'h0000_2083, 32'h0010_1067};
    case (k)
      K_ADDI:   return {imm[11:0], rs1, 3'd0, rd, 7'h13};
      K_ADD:    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
      K_LUI:    return {imm[19:0], rd, 7'h37};
      K_AUIPC:  return {imm[19:0], rd, 7'h17};
      K_JAL:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
      K_JALR:   return {imm[11:0], rs1, 3'd0, rd, 7'h67};
      K_EBREAK: return 32'h0010_0073;
      default:  return ill[imm % 6];
    endcase
  endfunction
  task automatic chk_state(input string tag);
    chk({tag, "_pc"}, o_pc, m_pc);
    chk({tag, "_halt"}, 32'(o_halt), 32'(m_halt));
    chk({tag, "_fault"}, 32'(o_fault), 32'(m_fault));
    chk({tag, "_valid"}, 32'(o_valid), 32'(!m_halt));
    chk({tag, "_commit"}, 32'(o_commit), 32'd0);
  endtask
  task automatic do_reset(input logic s);
    sel = s;
    rst = 1;
    ready = 0;
    rsp_valid = 1'($urandom_range(0, 1));
    rsp_inst = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pc", o_pc, RPC);
    chk("rst_commit", 32'(o_commit), 32'd0);
    chk("rst_halt", 32'(o_halt), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    rst = 0;
    rsp_valid = 0;
    foreach (m_x[i]) m_x[i] = '0;
    m_pc = RPC;
    m_halt = 0;
    m_fault = 0;
    #1;
  endtask
  task automatic freeze();
    repeat (3) begin
      rsp_valid = 1;
      rsp_inst = $urandom;
      ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_state("frozen");
    end
    rsp_valid = 0;
    ready = 0;
  endtask
  task automatic run_insn(input kind_t k, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm,
                          input int rq_d, input int rs_d);
    logic [31:0] w = enc(k, rd, rs1, rs2, imm);
    int nr = sel ? 16 : 32;
    int tmo = sel ? 3 : 255;
    logic to = rs_d >= tmo;
    int n = to ? tmo - 1 : rs_d;
    logic [31:0] a, b, res, np;
    logic legal, urd, urs1;
    for (int c = 0; c <= rq_d; c++) begin
      chk("req_valid", 32'(o_valid), 32'd1);
      chk("req_addr", o_addr, m_pc);
      ready = c == rq_d;
      rsp_valid = 1'($urandom_range(0, 1));
      rsp_inst = $urandom;
      @(negedge clk);
    end
    ready = 0;
    for (int c = 0; c <= n; c++) begin
      chk("wait_valid", 32'(o_valid), 32'd0);
      chk("wait_commit", 32'(o_commit), 32'd0);
      rsp_valid = !to && c == rs_d;
      rsp_inst = rsp_valid ? w : $urandom;
      @(negedge clk);
    end
    rsp_valid = 0;
    if (to) begin
      m_halt = 1;
      m_fault = 3;
      chk_state("timeout");
      return;
    end
    a = m_x[rs1];
    b = m_x[rs2];
    urd = k inside {K_ADDI, K_ADD, K_LUI, K_AUIPC, K_JAL, K_JALR};
    urs1 = k inside {K_ADDI, K_ADD, K_JALR};
    legal = k != K_ILL && !(nr == 16 && ((urd && rd >= 16) || (urs1 && rs1 >= 16) ||
                                         (k == K_ADD && rs2 >= 16)));
    res = m_pc + 4;
    np = m_pc + 4;
    case (k)
      K_ADDI:  res = a + {{20{imm[11]}}, imm[11:0]};
      K_ADD:   res = a + b;
      K_LUI:   res = imm[19:0] << 12;
      K_AUIPC: res = m_pc + (imm[19:0] << 12);
      K_JAL:   np = m_pc + {{11{imm[20]}}, imm[20:1], 1'b0};
      K_JALR:  np = (a + {{20{imm[11]}}, imm[11:0]}) & ~32'd1;
      default: ;
    endcase
    chk("exec_commit", 32'(o_commit), 32'(legal));
    chk("exec_pc", o_pc, m_pc);
    chk("exec_valid", 32'(o_valid), 32'd0);
    rsp_valid = 1'($urandom_range(0, 1));
    rsp_inst = $urandom;
    @(negedge clk);
    rsp_valid = 0;
    if (!legal) begin
      m_halt = 1;
      m_fault = 2;
    end else if (k == K_EBREAK) begin
      m_halt = 1;
      m_fault = 1;
    end else begin
      if (rd != 0) m_x[rd] = res;
      m_pc = np;
    end
    chk_state("post");
  endtask
  task automatic rand_insn();
    int p = $urandom_range(0, 99);
    int top = (sel && $urandom_range(0, 19) == 0) ? 31 : (sel ? 15 : 31);
    kind_t k = p < 2 ? K_ILL : p < 4 ? K_EBREAK : p < 30 ? K_ADDI : p < 50 ? K_ADD :
               p < 60 ? K_LUI : p < 70 ? K_AUIPC : p < 85 ? K_JAL : K_JALR;
    int rs_d = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
    run_insn(k, 5'($urandom_range(0, top)), 5'($urandom_range(0, top)), 5'($urandom_range(0, top)),
             $urandom, $urandom_range(0, 2), rs_d);
  endtask
  initial begin
    logic [31:0] p;
    do_reset(0);
    run_insn(K_ADDI, 1, 0, 0, 5, 0, 0);
    chk("addi_pc", o_pc, 32'h8000_0004);
    run_insn(K_ADDI, 2, 1, 0, 0, 4, 0);
    run_insn(K_LUI, 1, 0, 0, 32'h80000, 0, 1);
    run_insn(K_ADDI, 1, 1, 0, 32'h11, 0, 0);
    p = m_pc;
    run_insn(K_JALR, 1, 1, 0, 0, 0, 0);
    chk("jalr_pc", o_pc, 32'h8000_0010);
    run_insn(K_JALR, 0, 1, 0, 0, 0, 0);
    chk("jalr_link", o_pc, p + 4);
    ready = 1;
    @(negedge clk);
    ready = 0;
    rst = 1;
    @(negedge clk);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    rst = 0;
    rsp_valid = 1;
    rsp_inst = enc(K_ADDI, 3, 0, 0, 7);
    #1;
    foreach (m_x[i]) m_x[i] = '0;
    m_pc = RPC;
    @(negedge clk);
    rsp_valid = 0;
    chk("stale_rsp_commit", 32'(o_commit), 32'd0);
    chk("stale_rsp_valid", 32'(o_valid), 32'd1);
    run_insn(K_JALR, 0, 3, 0, 0, 0, 0);
    run_insn(K_EBREAK, 0, 0, 0, 0, 0, 0);
    chk("ebreak_fault", 32'(o_fault), 32'd1);
    freeze();
    do_reset(1);
    run_insn(K_ADDI, 1, 0, 0, 9, 0, 0);
    run_insn(K_ADD, 17, 1, 2, 0, 0, 0);
    chk("rv32e_fault", 32'(o_fault), 32'd2);
    chk("rv32e_pc", o_pc, 32'h8000_0004);
    freeze();
    do_reset(1);
    run_insn(K_ADDI, 1, 0, 0, 1, 0, 5);
    chk("timeout_fault", 32'(o_fault), 32'd3);
    freeze();
    do_reset(1);
    chk("restart_addr", o_addr, RPC);
    for (int s = 0; s < 2; s++) begin
      do_reset(1'(s));
      for (int i = 0; i < 200; i++) begin
        if (m_halt) begin
          freeze();
          do_reset(1'(s));
        end
        rand_insn();
      end
      if (!m_halt)
        for (int r = 1; r < (s ? 16 : 32); r++) run_insn(K_JALR, 0, 5'(r), 0, 0, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
